// File: rtl/qed_dup_issue_if.sv
// rtl/qed_dup_issue_if.sv - instruction-source / core-port bundle for qed_dup_issue
interface qed_dup_issue_if #(
    parameter int CNT_W = 16
);
    logic             ena;
    logic             exec_dup;
    logic [31:0]      ifu_qed_instruction;
    logic [31:0]      qed_instruction;
    logic             qed_vld_out;
    logic             qed_ready;
    logic [CNT_W-1:0] num_orig;
    logic [CNT_W-1:0] num_dup;
    logic             queue_full;
    logic             queue_empty;

    modport master (
        output ena, exec_dup, ifu_qed_instruction,
        input  qed_instruction, qed_vld_out, qed_ready,
        input  num_orig, num_dup, queue_full, queue_empty
    );

    modport slave (
        input  ena, exec_dup, ifu_qed_instruction,
        output qed_instruction, qed_vld_out, qed_ready,
        output num_orig, num_dup, queue_full, queue_empty
    );
endinterface

// File: rtl/qed_dup_issue.sv
// rtl/qed_dup_issue.sv - QED original issue / duplicate queue; QED_MEM_REMAP_EN adds +64 load/store offset remap
module qed_dup_issue #(
    parameter int DEPTH = 16,
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    qed_dup_issue_if.slave bus
);
    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_NOP    = 7'b1111111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;

    // Originals only use x0-x15 and offsets 0-63, so setting bit4 / imm[6] is the +16 / +64 shift.
    function automatic logic [31:0] dup_xform(input logic [31:0] ins);
        logic [31:0] r;
        logic        use_rd, use_rs1, use_rs2;
        r       = ins;
        use_rd  = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (ins[6:0])
            OP_R:                       begin use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_IMM, OP_LOAD, OP_JALR:   begin use_rd = 1'b1; use_rs1 = 1'b1; end
            OP_STORE, OP_BRANCH:        begin use_rs1 = 1'b1; use_rs2 = 1'b1; end
            OP_LUI, OP_AUIPC, OP_JAL:   use_rd = 1'b1;
            default:                    ;
        endcase
        if (use_rd  && ins[11:7]  != 5'd0) r[11] = 1'b1;
        if (use_rs1 && ins[19:15] != 5'd0) r[19] = 1'b1;
        if (use_rs2 && ins[24:20] != 5'd0) r[24] = 1'b1;
`ifdef QED_MEM_REMAP_EN
        if (ins[6:0] == OP_LOAD || ins[6:0] == OP_STORE) r[26] = 1'b1;
`endif
        return r;
    endfunction

    logic [31:0]      mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [31:0]      instr_q, instr_d;
    logic             vld_q, vld_d, ready_q, ready_d;
    logic [CNT_W-1:0] orig_q, orig_d, dup_q, dup_d;
    logic             push, pop, is_full, is_empty, pass_thru;

    assign is_full   = (cnt_q == FULL_CNT);
    assign is_empty  = (cnt_q == '0);
    assign pass_thru = (bus.ifu_qed_instruction[6:0] == OP_NOP)    ||
                       (bus.ifu_qed_instruction[6:0] == OP_SYSTEM) ||
                       (bus.ifu_qed_instruction[6:0] == OP_FENCE);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        instr_d  = instr_q;
        vld_d    = vld_q;
        ready_d  = ready_q;
        orig_d   = orig_q;
        dup_d    = dup_q;
        push     = 1'b0;
        pop      = 1'b0;
        if (bus.ena) begin
            vld_d = 1'b1;
            if ((bus.exec_dup && !is_empty) || is_full) begin
                pop      = 1'b1;
                instr_d  = mem_q[rd_ptr_q];
                rd_ptr_d = rd_ptr_q + 1'b1;
                cnt_d    = cnt_q - 1'b1;
                if (dup_q != '1) dup_d = dup_q + 1'b1;
            end else begin
                instr_d = bus.ifu_qed_instruction;
                if (!pass_thru) begin
                    push     = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                    cnt_d    = cnt_q + 1'b1;
                    if (orig_q != '1) orig_d = orig_q + 1'b1;
                end
            end
            ready_d = (orig_d == dup_d) && (orig_d != '0) && (cnt_d == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            instr_q  <= 32'h0000007F;
            vld_q    <= 1'b0;
            ready_q  <= 1'b0;
            orig_q   <= '0;
            dup_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            instr_q  <= instr_d;
            vld_q    <= vld_d;
            ready_q  <= ready_d;
            orig_q   <= orig_d;
            dup_q    <= dup_d;
        end
    end

    // Storage is not reset; the occupancy count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && push) mem_q[wr_ptr_q] <= dup_xform(bus.ifu_qed_instruction);
    end

    assign bus.qed_instruction = instr_q;
    assign bus.qed_vld_out     = vld_q;
    assign bus.qed_ready       = ready_q;
    assign bus.num_orig        = orig_q;
    assign bus.num_dup         = dup_q;
    assign bus.queue_full      = is_full;
    assign bus.queue_empty     = is_empty;
endmodule

// File: tb/tb_qed_dup_issue.sv
// tb/tb_qed_dup_issue.sv - bench for qed_dup_issue: queue-based reference model, directed and random stimulus
module tb_qed_dup_issue;
    localparam int DEPTH = 16;
    localparam int CNT_W = 16;
    localparam int CMAX  = 65535;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    qed_dup_issue_if #(.CNT_W(CNT_W)) bus ();
    qed_dup_issue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    logic [31:0] m_q[$];
    logic [31:0] m_out   = 32'h7F;
    bit          m_vld   = 1'b0;
    bit          m_ready = 1'b0;
    int          m_orig  = 0;
    int          m_dup   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_dup(input logic [31:0] ins);
        logic [31:0] o;
        int rd, rs1, rs2, imm;
        bit urd, urs1, urs2;
        o   = ins;
        rd  = int'(ins[11:7]);
        rs1 = int'(ins[19:15]);
        rs2 = int'(ins[24:20]);
        {urd, urs1, urs2} = 3'b000;
        case (ins[6:0])
            7'b0110011:                         {urd, urs1, urs2} = 3'b111;
            7'b0010011, 7'b0000011, 7'b1100111: {urd, urs1, urs2} = 3'b110;
            7'b0100011, 7'b1100011:             {urd, urs1, urs2} = 3'b011;
            7'b0110111, 7'b0010111, 7'b1101111: {urd, urs1, urs2} = 3'b100;
            default:                            {urd, urs1, urs2} = 3'b000;
        endcase
        if (urd  && rd  != 0) o[11:7]  = 5'(rd + 16);
        if (urs1 && rs1 != 0) o[19:15] = 5'(rs1 + 16);
        if (urs2 && rs2 != 0) o[24:20] = 5'(rs2 + 16);
`ifdef QED_MEM_REMAP_EN
        if (ins[6:0] == 7'b0000011) begin
            imm = int'(ins[31:20]) + 64;
            o[31:20] = 12'(imm);
        end
        if (ins[6:0] == 7'b0100011) begin
            imm = int'({ins[31:25], ins[11:7]}) + 64;
            o[31:25] = 7'(imm / 32);
        end
`endif
        return o;
    endfunction

    function automatic bit is_pass(input logic [31:0] ins);
        return ins[6:0] == 7'b1111111 || ins[6:0] == 7'b1110011 || ins[6:0] == 7'b0001111;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [11:0] imm, off;
        logic [19:0] u20;
        logic [24:0] r25;
        rd  = 5'($urandom_range(0, 15));
        rs1 = 5'($urandom_range(0, 15));
        rs2 = 5'($urandom_range(0, 15));
        f3  = 3'($urandom);
        imm = 12'($urandom);
        off = 12'($urandom_range(0, 63));
        u20 = 20'($urandom);
        r25 = 25'($urandom);
        case ($urandom_range(0, 11))
            0:  return {7'h00, rs2, rs1, f3, rd, 7'b0110011};
            1:  return {imm, rs1, f3, rd, 7'b0010011};
            2:  return {off, rs1, 3'b010, rd, 7'b0000011};
            3:  return {off[11:5], rs2, rs1, 3'b010, off[4:0], 7'b0100011};
            4:  return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'b1100011};
            5:  return {u20, rd, 7'b0110111};
            6:  return {u20, rd, 7'b0010111};
            7:  return {u20, rd, 7'b1101111};
            8:  return {imm, rs1, 3'b000, rd, 7'b1100111};
            9:  return 32'h0000007F;
            10: return {r25, 7'b1110011};
            default: return {r25, 7'b0001111};
        endcase
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_q.delete();
            m_out = 32'h7F; m_vld = 1'b0; m_ready = 1'b0; m_orig = 0; m_dup = 0;
        end else if (bus.ena) begin
            m_vld = 1'b1;
            if ((bus.exec_dup && m_q.size() > 0) || m_q.size() == DEPTH) begin
                m_out = m_q.pop_front();
                if (m_dup < CMAX) m_dup++;
            end else begin
                m_out = bus.ifu_qed_instruction;
                if (!is_pass(bus.ifu_qed_instruction)) begin
                    m_q.push_back(model_dup(bus.ifu_qed_instruction));
                    if (m_orig < CMAX) m_orig++;
                end
            end
            m_ready = (m_orig == m_dup) && (m_orig != 0) && (m_q.size() == 0);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("instr", bus.qed_instruction, m_out);
            check("vld", 32'(bus.qed_vld_out), 32'(m_vld));
            check("ready", 32'(bus.qed_ready), 32'(m_ready));
            check("num_orig", 32'(bus.num_orig), 32'(m_orig));
            check("num_dup", 32'(bus.num_dup), 32'(m_dup));
            check("full", 32'(bus.queue_full), 32'(m_q.size() == DEPTH));
            check("empty", 32'(bus.queue_empty), 32'(m_q.size() == 0));
        end
    end

    task automatic tick(input logic r, input logic e, input logic d, input logic [31:0] ins);
        @(negedge clk);
        rst = r; bus.ena = e; bus.exec_dup = d; bus.ifu_qed_instruction = ins;
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.ena = 1'b0; bus.exec_dup = 1'b0; bus.ifu_qed_instruction = 32'h0;

        tick(1, 0, 0, 32'h0);
        tick(1, 0, 0, 32'h0);
        chk_en = 1'b1;
        check("rst_vld", 32'(bus.qed_vld_out), 32'h0);
        check("rst_instr", bus.qed_instruction, 32'h0000007F);
        check("rst_empty", 32'(bus.queue_empty), 32'h1);
        check("rst_orig", 32'(bus.num_orig), 32'h0);

        tick(0, 1, 0, 32'h00510093);
        check("addi_orig", bus.qed_instruction, 32'h00510093);
        check("addi_norig", 32'(bus.num_orig), 32'h1);
        tick(0, 1, 1, 32'h00000013);
        check("addi_dup", bus.qed_instruction, 32'h00590893);
        check("addi_ndup", 32'(bus.num_dup), 32'h1);
        check("addi_ready", 32'(bus.qed_ready), 32'h1);

        tick(0, 1, 0, 32'h00802183);
        check("lw_orig", bus.qed_instruction, 32'h00802183);
        tick(0, 1, 1, 32'h00000013);
`ifdef QED_MEM_REMAP_EN
        check("lw_dup", bus.qed_instruction, 32'h04802983);
`else
        check("lw_dup", bus.qed_instruction, 32'h00802983);
`endif

        for (int i = 0; i < DEPTH; i++) tick(0, 1, 0, {12'(i), 5'd2, 3'b000, 5'd1, 7'h13});
        check("fill_full", 32'(bus.queue_full), 32'h1);
        check("fill_orig", 32'(bus.num_orig), 32'd18);
        tick(0, 1, 0, 32'h00100113);
        check("forced_dup", bus.qed_instruction, 32'h00090893);
        check("forced_ndup", 32'(bus.num_dup), 32'd3);
        check("forced_orig", 32'(bus.num_orig), 32'd18);
        check("forced_notfull", 32'(bus.queue_full), 32'h0);
        for (int i = 1; i < DEPTH; i++) tick(0, 1, 1, 32'h00000013);
        check("drain_empty", 32'(bus.queue_empty), 32'h1);

        tick(1, 0, 0, 32'h0);
        tick(0, 1, 0, 32'h0000007F);
        check("nop_out", bus.qed_instruction, 32'h0000007F);
        check("nop_orig", 32'(bus.num_orig), 32'h0);
        check("nop_empty", 32'(bus.queue_empty), 32'h1);
        check("nop_ready", 32'(bus.qed_ready), 32'h0);
        tick(0, 1, 1, 32'h00000073);
        check("empty_dup_falls_orig", bus.qed_instruction, 32'h00000073);

        for (int i = 1; i <= 4; i++) tick(0, 1, 0, {12'(i), 5'd3, 3'b000, 5'd4, 7'h13});
        for (int i = 0; i < 3; i++) tick(0, 0, i[0], 32'h00000033);
        check("frz_orig", 32'(bus.num_orig), 32'd4);
        check("frz_instr", bus.qed_instruction, 32'h00418213);
        check("frz_vld", 32'(bus.qed_vld_out), 32'h1);
        tick(0, 1, 0, 32'h00500113);
        tick(1, 1, 1, 32'h00500113);
        check("mid_rst_empty", 32'(bus.queue_empty), 32'h1);
        check("mid_rst_orig", 32'(bus.num_orig), 32'h0);
        check("mid_rst_dup", 32'(bus.num_dup), 32'h0);
        check("mid_rst_vld", 32'(bus.qed_vld_out), 32'h0);

        for (int i = 0; i < 4000; i++) begin
            tick(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) < 8),
                 ($urandom_range(0, 9) < 4), rand_instr());
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
